// File: rtl/vga_sync_gen.sv
// VGA timing generator: clock divider, pixel/line counters and registered
// sync/blanking decode aligned with the counter values they describe.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned DIV       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = $clog2(DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DISP   = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP   = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  if (DIV < 2) begin : g_div_check
    $error("vga_sync_gen: DIV must be at least 2");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [9:0]       x_nxt;
  logic [9:0]       y_nxt;

  // Strobes are gated by en so they drop immediately while timing is paused.
  assign p_tick     = en && (div_cnt == DIV_LAST);
  assign frame_tick = p_tick && (pixel_x == H_LAST) && (pixel_y == V_LAST);

  // Next counter values; decode below is taken from these so flops stay aligned.
  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    x_nxt   = pixel_x;
    y_nxt   = pixel_y;
    if (p_tick) begin
      if (pixel_x == H_LAST) begin
        x_nxt = '0;
        y_nxt = (pixel_y == V_LAST) ? '0 : pixel_y + 10'd1;
      end else begin
        x_nxt = pixel_x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      pixel_x  <= '0;
      pixel_y  <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b1;
    end else if (en) begin
      div_cnt  <= div_nxt;
      pixel_x  <= x_nxt;
      pixel_y  <= y_nxt;
      hsync    <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
      vsync    <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
      video_on <= (x_nxt < H_DISP) && (y_nxt < V_DISP);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default horizontal timing, shortened vertical
// timing (7 lines/frame) so a whole frame fits in a short run.
module tb_vga_sync_gen;

  localparam int V_DISP = 3;
  localparam int V_FP   = 1;
  localparam int V_SW   = 2;
  localparam int V_BP   = 1;
  localparam int V_TOT  = V_DISP + V_FP + V_SW + V_BP;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;

  vga_sync_gen #(
    .V_DISPLAY(V_DISP), .V_FRONT(V_FP), .V_SYNC(V_SW), .V_BACK(V_BP)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .p_tick(p_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
  } st_t;

  typedef struct {
    int   c;
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic von;
    logic pt;
    logic ft;
  } vec_t;

  st_t  sb[$];
  vec_t tbl[15];

  int   errors = 0;
  int   checks = 0;
  int   m_div = 0, m_x = 0, m_y = 0, cyc = 0;
  bit   meas = 1'b0;
  int   n_hs = 0, n_vs = 0, n_ft = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (model x=%0d y=%0d div=%0d)",
               nm, act, exp, m_x, m_y, m_div);
    end
  endtask

  // One clk: check strobes mid-cycle, advance model, push expectation, compare after edge.
  task automatic tick(input logic r, input logic e);
    st_t  ex;
    st_t  act;
    logic ept;
    logic eft;
    @(negedge clk);
    rst = r;
    en  = e;
    #1;
    ept = e && (m_div == 3);
    eft = ept && (m_x == 799) && (m_y == V_TOT - 1);
    chk("p_tick", 32'(p_tick), 32'(ept));
    chk("frame_tick", 32'(frame_tick), 32'(eft));
    if (meas && frame_tick) n_ft++;
    if (r) begin
      m_div = 0; m_x = 0; m_y = 0; cyc = 0;
    end else if (e) begin
      cyc++;
      if (m_div == 3) begin
        m_div = 0;
        if (m_x == 799) begin
          m_x = 0;
          m_y = (m_y == V_TOT - 1) ? 0 : m_y + 1;
        end else begin
          m_x++;
        end
      end else begin
        m_div++;
      end
    end
    ex.x   = 10'(m_x);
    ex.y   = 10'(m_y);
    ex.hs  = !(m_x >= 656 && m_x < 752);
    ex.vs  = !(m_y >= V_DISP + V_FP && m_y < V_DISP + V_FP + V_SW);
    ex.von = (m_x < 640) && (m_y < V_DISP);
    sb.push_back(ex);
    @(posedge clk);
    #1;
    ex  = sb.pop_front();
    act = '{x: pixel_x, y: pixel_y, hs: hsync, vs: vsync, von: video_on};
    chk("state{x,y,hs,vs,von}", 32'(act), 32'(ex));
    if (meas) begin
      if (m_y == 0 && !hsync) n_hs++;
      if (!vsync) n_vs++;
    end
  endtask

  task automatic seek(input int x, input int y, input int d);
    int k = 0;
    while (!(m_x == x && m_y == y && m_div == d) && k < 30000) begin
      tick(1'b0, 1'b1);
      k++;
    end
    chk("seek_reached", 32'(m_x == x && m_y == y && m_div == d), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //            c      x    y  hs vs von pt ft
    tbl[0]  = '{    3,   0,  0, 1, 1, 1, 1, 0};
    tbl[1]  = '{    4,   1,  0, 1, 1, 1, 0, 0};
    tbl[2]  = '{ 2559, 639,  0, 1, 1, 1, 1, 0};
    tbl[3]  = '{ 2560, 640,  0, 1, 1, 0, 0, 0};
    tbl[4]  = '{ 2623, 655,  0, 1, 1, 0, 1, 0};
    tbl[5]  = '{ 2624, 656,  0, 0, 1, 0, 0, 0};
    tbl[6]  = '{ 3007, 751,  0, 0, 1, 0, 1, 0};
    tbl[7]  = '{ 3008, 752,  0, 1, 1, 0, 0, 0};
    tbl[8]  = '{ 3200,   0,  1, 1, 1, 1, 0, 0};
    tbl[9]  = '{ 9600,   0,  3, 1, 1, 0, 0, 0};
    tbl[10] = '{12800,   0,  4, 1, 0, 0, 0, 0};
    tbl[11] = '{19199, 799,  5, 1, 0, 0, 1, 0};
    tbl[12] = '{19200,   0,  6, 1, 1, 0, 0, 0};
    tbl[13] = '{22399, 799,  6, 1, 1, 0, 1, 1};
    tbl[14] = '{22400,   0,  0, 1, 1, 1, 0, 0};

    tick(1'b1, 1'b0);
    chk("reset_state", 32'({pixel_x, pixel_y, hsync, vsync, video_on, p_tick, frame_tick}),
        32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}));

    // One full frame from reset against hand-derived checkpoints.
    meas = 1'b1;
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < 30000 && cyc < tbl[i].c; k++) tick(1'b0, 1'b1);
      chk($sformatf("vec[%0d]", i),
          32'({pixel_x, pixel_y, hsync, vsync, video_on, p_tick, frame_tick}),
          32'({10'(tbl[i].x), 10'(tbl[i].y), tbl[i].hs, tbl[i].vs, tbl[i].von,
               tbl[i].pt, tbl[i].ft}));
    end
    meas = 1'b0;
    chk("hsync_low_clks_line0", 32'(n_hs), 32'd384);
    chk("vsync_low_clks_frame", 32'(n_vs), 32'd6400);
    chk("frame_ticks_per_frame", 32'(n_ft), 32'd1);

    // Pause mid-frame: everything frozen, then resume with divider phase kept.
    seek(300, 2, 1);
    for (int k = 0; k < 100; k++) tick(1'b0, 1'b0);
    chk("hold_xy", 32'({pixel_x, pixel_y}), 32'({10'd300, 10'd2}));
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk("resume_ptick", 32'({p_tick, pixel_x}), 32'({1'b1, 10'd300}));

    // Last pixel of frame with en low suppresses frame_tick; then wrap.
    seek(799, V_TOT - 1, 3);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("wrap_xy", 32'({pixel_x, pixel_y}), 32'({10'd0, 10'd0}));

    // Reset during hsync and vsync low.
    seek(700, 5, 2);
    chk("pre_reset_sync", 32'({hsync, vsync}), 32'({1'b0, 1'b0}));
    tick(1'b1, 1'b1);
    chk("post_reset", 32'({pixel_x, pixel_y, hsync, vsync, video_on}),
        32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1}));
    chk("post_reset_ptick0", 32'(p_tick), 32'd0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk("post_reset_ptick2", 32'(p_tick), 32'd0);
    tick(1'b0, 1'b1);
    chk("post_reset_ptick3", 32'({p_tick, pixel_x}), 32'({1'b1, 10'd0}));
    tick(1'b0, 1'b1);
    chk("post_reset_x1", 32'(pixel_x), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_DISPLAY, 640: visible pixels per line.
REQ-002 Parameter H_FRONT, 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, 96: horizontal sync width, in pixels.
REQ-004 Parameter H_BACK, 48: horizontal back porch, in pixels.
REQ-005 Parameter V_DISPLAY, 480: visible lines per frame.
REQ-006 Parameter V_FRONT, 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, 2: vertical sync width, in lines.
REQ-008 Parameter V_BACK, 33: vertical back porch, in lines.
REQ-009 Parameter DIV, 4: system clocks per pixel; the block SHALL require DIV >= 2.
REQ-010 clk  input  1: system clock; all state SHALL update on the rising edge of clk only.
REQ-011 rst  input  1: synchronous, active-high reset.
REQ-012 en  input  1: timing enable; all counters SHALL hold while en is low.
REQ-013 p_tick  output  1: pixel strobe, one clk cycle wide.
REQ-014 pixel_x  output  10: current horizontal count, 0 to H_TOTAL-1.
REQ-015 pixel_y  output  10: current vertical count, 0 to V_TOTAL-1.
REQ-016 video_on  output  1: high when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY.
REQ-017 hsync  output  1: horizontal sync, active low.
REQ-018 vsync  output  1: vertical sync, active low.
REQ-019 frame_tick  output  1: one-clk pulse marking the last pixel of a frame; the downstream pixel generator uses it to pace object motion.

Function
REQ-020 H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800), and V_TOTAL SHALL equal V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-021 Divider: div_cnt SHALL increment by one per clk while en is high and wrap from DIV-1 to 0.
REQ-022 p_tick SHALL be high exactly in the clk cycles where div_cnt == DIV-1 and en is high.
REQ-023 On each clk edge where p_tick is high, pixel_x SHALL increment by one; at H_TOTAL-1 it SHALL wrap to 0.
REQ-024 pixel_y SHALL increment only on the edge where pixel_x wraps; at V_TOTAL-1 it SHALL wrap to 0, so both counters reach 0 on the same edge.
REQ-025 While en is low, div_cnt, pixel_x, pixel_y, hsync, vsync and video_on SHALL hold, and p_tick and frame_tick SHALL be 0.
REQ-026 hsync SHALL be 0 iff H_DISPLAY+H_FRONT <= pixel_x < H_DISPLAY+H_FRONT+H_SYNC, i.e. pixel_x from 656 to 751.
REQ-027 vsync SHALL be 0 iff V_DISPLAY+V_FRONT <= pixel_y < V_DISPLAY+V_FRONT+V_SYNC, i.e. pixel_y from 490 to 491.
REQ-028 hsync, vsync and video_on SHALL be flop outputs (next-state decode registered) and SHALL be cycle-aligned with the pixel_x/pixel_y values they describe, with zero lag and no combinational glitches.
REQ-029 frame_tick SHALL be high for exactly one clk cycle: the cycle where p_tick == 1, pixel_x == H_TOTAL-1 and pixel_y == V_TOTAL-1.
REQ-030 pixel_x and pixel_y SHALL never exceed H_TOTAL-1 and V_TOTAL-1, and no wrap SHALL skip or repeat a count.

Reset
REQ-031 When rst is high at a clk edge, the block SHALL set, on that edge: div_cnt=0, pixel_x=0, pixel_y=0, p_tick=0, frame_tick=0, hsync=1, vsync=1, video_on=1.
REQ-032 rst SHALL take priority over en and over any pending wrap.
REQ-033 A reset asserted mid-frame SHALL restart timing at (0,0), and the first p_tick SHALL occur DIV-1 clks after rst deasserts.

Verification
REQ-034 Reset release with en=1, defaults -> p_tick first high in clk cycle 3 after release, then every 4 clks; pixel_x reads 1 after that first p_tick edge.
REQ-035 Run one line -> video_on falls when pixel_x becomes 640; hsync is low for exactly 96 p_ticks (384 clks) starting at pixel_x=656; the line period is 3200 clks.
REQ-036 Run one frame -> vsync is low for 2 lines (6400 clks) starting at pixel_y=490; exactly one frame_tick occurs per 1,680,000 clks; after the frame_tick edge, pixel_x=0 and pixel_y=0.
REQ-037 Hold en low for 100 clks at pixel_x=300, pixel_y=200 -> all outputs are frozen, with p_tick=0 and frame_tick=0; timing resumes from div_cnt unchanged.
REQ-038 Assert rst for 1 clk at pixel_x=700, pixel_y=491 (hsync=0, vsync=0) -> the next cycle shows pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1.
REQ-039 Wrap check at pixel_x=799, pixel_y=524 -> on one edge both counters go to 0 and frame_tick has pulsed once; the counters never read 800 or 525.
